booth_seq_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier that consumes the two signed operands produced by the keypad digit-entry logic. It is the reader side of that interface. It accepts an operand pair on a single-cycle start strobe and iterates one Booth step per clock. It then presents a registered two's-complement product, plus an optional sign/magnitude form, to the BCD conversion and 7-segment display path.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_step.sv | 35 +++
 rtl/booth_seq_multiplier.sv | 128 ++++++++++++
 tb/tb_booth_seq_multiplier.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Step counter runs 0..w-1.
  function automatic int unsigned step_cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DEFAULT_STEP_CNT_W = step_cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of sext(m) into acc, then
// arithmetic right shift of {acc, q, q_1}. Purely combinational.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_c,
  output logic [WIDTH-1:0] q_c,
  output logic             q_1_c
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
  end

  assign acc_c = {sum[WIDTH], sum[WIDTH:1]};
  assign q_c   = {sum[0], q[WIDTH-1:1]};
  assign q_1_c = q[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, one step per clock, fixed WIDTH+2 cycle cadence.
// Define BOOTH_MAG_OUT_EN to add registered sign/magnitude outputs prod_neg/prod_mag.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef BOOTH_MAG_OUT_EN
  ,
  output logic               prod_neg,
  output logic [2*WIDTH-2:0] prod_mag
`endif
);

  localparam int unsigned CNT_W  = step_cnt_w(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  booth_state_e state, state_next;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [CNT_W-1:0] cnt_q;

  logic load_c, step_c, last_c;

  logic [WIDTH:0]    acc_s;
  logic [WIDTH-1:0]  q_s;
  logic              q1_s;
  logic [PROD_W-1:0] prod_s;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc   (acc_q),
    .q     (q_q),
    .q_1   (q1_q),
    .m     (m_q),
    .acc_c (acc_s),
    .q_c   (q_s),
    .q_1_c (q1_s)
  );

  // Result of the final step is what gets latched on the edge entering DONE.
  assign prod_s = {acc_s[WIDTH-1:0], q_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    last_c     = (cnt_q == CNT_W'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          load_c     = 1'b1;
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (last_c) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (load_c) begin
        m_q   <= op_a;
        acc_q <= '0;
        q_q   <= op_b;
        q1_q  <= 1'b0;
        cnt_q <= '0;
      end else if (step_c) begin
        acc_q <= acc_s;
        q_q   <= q_s;
        q1_q  <= q1_s;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_c) product <= prod_s;
      end
    end
  end

`ifdef BOOTH_MAG_OUT_EN
  localparam int unsigned MAG_W = PROD_W - 1;

  logic [PROD_W-1:0] prod_abs_c;

  // Magnitude always fits MAG_W bits, including the +2^(2W-2) corner.
  assign prod_abs_c = prod_s[PROD_W-1] ? (~prod_s + PROD_W'(1)) : prod_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_neg <= 1'b0;
      prod_mag <= '0;
    end else if (step_c && last_c) begin
      prod_neg <= prod_s[PROD_W-1];
      prod_mag <= MAG_W'(prod_abs_c);
    end
  end
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed self-checking bench for booth_seq_multiplier at WIDTH=8.
module tb_booth_seq_multiplier;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef BOOTH_MAG_OUT_EN
  logic           prod_neg;
  logic [2*W-2:0] prod_mag;
`endif

  int tests = 0;
  int fails = 0;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .op_a    (op_a),
    .op_b    (op_b),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef BOOTH_MAG_OUT_EN
    ,
    .prod_neg(prod_neg),
    .prod_mag(prod_mag)
`endif
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle, then observe 12 negedges (k = cycles after accept edge).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] p, output int done_k,
                       output int done_n, output int busy_n);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    p      = '0;
    done_k = 0;
    done_n = 0;
    busy_n = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          p      = product;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (product !== 16'h0000) begin fails++; $display("FAIL reset_product: got %h want 0000", product); end
`ifdef BOOTH_MAG_OUT_EN
    tests++; if (prod_neg !== 1'b0 || prod_mag !== 15'd0) begin
      fails++; $display("FAIL reset_mag: got neg=%b mag=%0d want 0/0", prod_neg, prod_mag);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p;
    int dk, dn, bn;
    do_op(8'd7, 8'hFD, p, dk, dn, bn);
    tests++; if (p !== 16'hFFEB) begin fails++; $display("FAIL basic_product: got %h want ffeb", p); end
    tests++; if (dk !== 9) begin fails++; $display("FAIL basic_latency: got %0d want 9", dk); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", dn); end
    tests++; if (bn !== 9) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 9", bn); end
    @(negedge clk);
    tests++; if (product !== 16'hFFEB) begin fails++; $display("FAIL basic_hold: got %h want ffeb", product); end
  endtask

  task automatic test_corners();
    logic [W-1:0]   av [6];
    logic [W-1:0]   bv [6];
    logic [2*W-1:0] ev [6];
    logic [2*W-1:0] p;
    int dk, dn, bn;
    av = '{8'h80, 8'h80, 8'h00, 8'hFF, 8'h7F, 8'h80};
    bv = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h7F, 8'h01};
    ev = '{16'h4000, 16'hC080, 16'h0000, 16'h0001, 16'h3F01, 16'hFF80};
    for (int i = 0; i < 6; i++) begin
      do_op(av[i], bv[i], p, dk, dn, bn);
      tests++; if (p !== ev[i]) begin
        fails++; $display("FAIL corner_product[%0d]: got %h want %h", i, p, ev[i]);
      end
      tests++; if (dk !== 9) begin
        fails++; $display("FAIL corner_latency[%0d]: got %0d want 9", i, dk);
      end
`ifdef BOOTH_MAG_OUT_EN
      if (i == 1) begin
        tests++; if (prod_neg !== 1'b1 || prod_mag !== 15'd16256) begin
          fails++; $display("FAIL corner_mag: got neg=%b mag=%0d want 1/16256", prod_neg, prod_mag);
        end
      end
      if (i == 0) begin
        tests++; if (prod_neg !== 1'b0 || prod_mag !== 15'd16384) begin
          fails++; $display("FAIL corner_mag_pos: got neg=%b mag=%0d want 0/16384", prod_neg, prod_mag);
        end
      end
`endif
    end
  endtask

  task automatic test_ignore_start();
    int dn, dk;
    logic [2*W-1:0] p;
    @(negedge clk);
    op_a  = 8'd6;
    op_b  = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    dk = 0;
    p  = '0;
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        dn++;
        if (dk == 0) begin dk = k; p = product; end
      end
      if (k == 3) begin op_a = 8'd9; op_b = 8'd9; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (k == 5) begin op_a = 8'd100; op_b = 8'hC3; end
    end
    tests++; if (p !== 16'h001E) begin fails++; $display("FAIL ignore_product: got %h want 001e", p); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
    tests++; if (dk !== 9) begin fails++; $display("FAIL ignore_latency: got %0d want 9", dk); end
  endtask

  task automatic test_reset_abort();
    int dn, dk, bn;
    logic [2*W-1:0] p;
    @(negedge clk);
    op_a  = 8'd12;
    op_b  = 8'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    tests++; if (product !== 16'h0000) begin fails++; $display("FAIL abort_product: got %h want 0000", product); end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    tests++; if (dn !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", dn); end
    do_op(8'd12, 8'd12, p, dk, dn, bn);
    tests++; if (p !== 16'h0090) begin fails++; $display("FAIL abort_restart: got %h want 0090", p); end
  endtask

  task automatic test_back_to_back();
    int dn;
    int bad_pos;
    int bad_prod;
    @(negedge clk);
    op_a  = 8'd2;
    op_b  = 8'd3;
    start = 1'b1;
    dn = 0;
    bad_pos = 0;
    bad_prod = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if ((k % 10) != 9) bad_pos++;
        if (product !== 16'h0006) bad_prod++;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    tests++; if (dn !== 3) begin fails++; $display("FAIL b2b_done_count: got %0d want 3", dn); end
    tests++; if (bad_pos !== 0) begin fails++; $display("FAIL b2b_spacing: got %0d off-cadence pulses want 0", bad_pos); end
    tests++; if (bad_prod !== 0) begin fails++; $display("FAIL b2b_product: got %0d wrong products want 0", bad_prod); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
